// File: rtl/alu_pkg.sv
// alu_pkg: shared types and constants for the ALU result selector
package alu_pkg;
   localparam int ERR_CNT_W  = 8;
   localparam int DEF_WIDTH  = 8;
   localparam int DEF_NUM_IN = 16;
   typedef enum logic [1:0] {EMPTY, ONE, TWO} occ_e;
endpackage

// File: rtl/alu_skid_buf.sv
// alu_skid_buf: 2-entry in-order skid buffer with registered ready
module alu_skid_buf
   import alu_pkg::*;
#(
   parameter int EW = 13
)(
   input  logic          clk,
   input  logic          rst_n,
   input  logic [EW-1:0] in_data_i,
   input  logic          in_valid_i,
   output logic          in_ready_o,
   output logic [EW-1:0] out_data_o,
   output logic          out_valid_o,
   input  logic          out_ready_i
);
   occ_e          state_q, state_d;
   logic [EW-1:0] e0_q, e1_q;
   logic          rdy_q, acc, del;
   assign acc = in_valid_i & rdy_q;
   assign del = (state_q != EMPTY) & out_ready_i;
   // Occupancy next state; TWO never accepts since ready is low there
   always_comb
      state_d = (state_q == EMPTY) ? (acc ? ONE : EMPTY)
              : (state_q == ONE)   ? ((acc & ~del) ? TWO : (~acc & del) ? EMPTY : ONE)
              : (del ? ONE : TWO);
   // State, registered ready and entries; e0 always holds the oldest entry
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state_q <= EMPTY;
         rdy_q   <= 1'b0;
         e0_q    <= '0;
         e1_q    <= '0;
      end else begin
         state_q <= state_d;
         rdy_q   <= state_d != TWO;
         if (state_q == TWO && del) e0_q <= e1_q;
         else if (acc && (state_q == EMPTY || del)) e0_q <= in_data_i;
         if (acc && state_q == ONE && !del) e1_q <= in_data_i;
      end
   assign in_ready_o  = rdy_q;
   assign out_valid_o = state_q != EMPTY;
   assign out_data_o  = e0_q;
endmodule

// File: rtl/alu_result_sel.sv
// alu_result_sel: selects one of NUM_IN inputs, flags illegal selects, buffers results
module alu_result_sel
   import alu_pkg::*;
#(
   parameter int WIDTH  = DEF_WIDTH,
   parameter int NUM_IN = DEF_NUM_IN,
   parameter int SEL_W  = $clog2(NUM_IN)
)(
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [NUM_IN*WIDTH-1:0] in_data,
   input  logic [SEL_W-1:0]        in_sel,
   input  logic                    in_valid,
   output logic                    in_ready,
   output logic [WIDTH-1:0]        out_data,
   output logic [SEL_W-1:0]        out_sel,
   output logic                    out_illegal,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [ERR_CNT_W-1:0]    err_count
);
   localparam int EW   = WIDTH + SEL_W + 1;
   localparam bit POW2 = (NUM_IN & (NUM_IN - 1)) == 0;
   logic [WIDTH-1:0]     slice [NUM_IN];
   logic                 illegal;
   logic [WIDTH-1:0]     sel_data;
   logic [EW-1:0]        out_ent;
   logic [ERR_CNT_W-1:0] err_q;
   for (genvar g = 0; g < NUM_IN; g++) begin : g_slice
      assign slice[g] = in_data[g*WIDTH +: WIDTH];
   end
   assign illegal  = !POW2 && (32'(in_sel) >= NUM_IN);
   assign sel_data = illegal ? '0 : slice[in_sel];
   alu_skid_buf #(.EW(EW)) u_buf (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_data_i   ({illegal, in_sel, sel_data}),
      .in_valid_i  (in_valid),
      .in_ready_o  (in_ready),
      .out_data_o  (out_ent),
      .out_valid_o (out_valid),
      .out_ready_i (out_ready)
   );
   assign out_data    = out_ent[WIDTH-1:0];
   assign out_sel     = out_ent[WIDTH +: SEL_W];
   assign out_illegal = !POW2 && out_ent[EW-1];
   // Saturating count of accepted illegal-select transactions
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) err_q <= '0;
      else if (in_valid && in_ready && illegal && err_q != '1) err_q <= err_q + 1'b1;
   assign err_count = err_q;
endmodule

// File: tb/tb_alu_result_sel.sv
// tb_alu_result_sel: table, directed and random checks of alu_result_sel against a queue model
module tb_alu_result_sel;
   typedef struct {logic [7:0] d; logic [3:0] s; logic il;} ent_t;
   typedef struct {logic [3:0] sel; logic [7:0] ad; logic [7:0] bd; logic bil; logic [7:0] berr;} vec_t;

   logic         clk = 0;
   logic         rst_n;
   logic [127:0] in_data;
   logic [3:0]   in_sel;
   logic         in_valid, out_ready;
   logic         a_in_ready, a_out_illegal, a_out_valid;
   logic [7:0]   a_out_data, a_err;
   logic [3:0]   a_out_sel;
   logic         b_in_ready, b_out_illegal, b_out_valid;
   logic [7:0]   b_out_data, b_err;
   logic [3:0]   b_out_sel;

   int   n_chk = 0, n_fail = 0;
   ent_t qa[$], qb[$];
   int   ea = 0, eb = 0;
   bit   m_rdy = 0;
   vec_t tbl[6];

   always #5 clk = ~clk;

   alu_result_sel #(.WIDTH(8), .NUM_IN(16)) dut_a (
      .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_sel(in_sel), .in_valid(in_valid),
      .in_ready(a_in_ready), .out_data(a_out_data), .out_sel(a_out_sel), .out_illegal(a_out_illegal),
      .out_valid(a_out_valid), .out_ready(out_ready), .err_count(a_err));

   alu_result_sel #(.WIDTH(8), .NUM_IN(11)) dut_b (
      .clk(clk), .rst_n(rst_n), .in_data(in_data[87:0]), .in_sel(in_sel), .in_valid(in_valid),
      .in_ready(b_in_ready), .out_data(b_out_data), .out_sel(b_out_sel), .out_illegal(b_out_illegal),
      .out_valid(b_out_valid), .out_ready(out_ready), .err_count(b_err));

   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic chk_side(string p, logic rdy, logic vld, logic [7:0] d, logic [3:0] s, logic il,
                           logic [7:0] err, ent_t q[$], int e);
      chk({p, "_in_ready"}, rdy, m_rdy);
      chk({p, "_out_valid"}, vld, q.size() > 0);
      if (q.size() > 0) begin
         chk({p, "_out_data"}, d, q[0].d);
         chk({p, "_out_sel"}, s, q[0].s);
         chk({p, "_out_illegal"}, il, q[0].il);
      end
      chk({p, "_err_count"}, err, e);
   endtask

   // one clock: check outputs on the falling edge, advance the model on the rising edge
   task automatic cycle();
      ent_t na, nb;
      bit   acc, del;
      @(negedge clk);
      chk_side("a", a_in_ready, a_out_valid, a_out_data, a_out_sel, a_out_illegal, a_err, qa, ea);
      chk_side("b", b_in_ready, b_out_valid, b_out_data, b_out_sel, b_out_illegal, b_err, qb, eb);
      acc   = in_valid && m_rdy;
      del   = (qa.size() > 0) && out_ready;
      na.s  = in_sel;
      na.il = 1'b0;
      na.d  = 8'(in_data >> (int'(in_sel) * 8));
      nb.s  = in_sel;
      nb.il = int'(in_sel) >= 11;
      nb.d  = nb.il ? 8'h00 : na.d;
      @(posedge clk);
      if (!rst_n) begin
         qa.delete(); qb.delete(); ea = 0; eb = 0; m_rdy = 0;
      end else begin
         if (del) begin void'(qa.pop_front()); void'(qb.pop_front()); end
         if (acc) begin
            qa.push_back(na); qb.push_back(nb);
            if (nb.il && eb < 255) eb++;
         end
         m_rdy = qa.size() < 2;
      end
      #1;
   endtask

   task automatic set_pattern();
      for (int k = 0; k < 16; k++) in_data[k*8 +: 8] = 8'hA0 + 8'(k);
   endtask

   initial begin
      tbl[0] = '{4'd12, 8'hAC, 8'h00, 1'b1, 8'd1};
      tbl[1] = '{4'd10, 8'hAA, 8'hAA, 1'b0, 8'd1};
      tbl[2] = '{4'd15, 8'hAF, 8'h00, 1'b1, 8'd2};
      tbl[3] = '{4'd0,  8'hA0, 8'hA0, 1'b0, 8'd2};
      tbl[4] = '{4'd11, 8'hAB, 8'h00, 1'b1, 8'd3};
      tbl[5] = '{4'd9,  8'hA9, 8'hA9, 1'b0, 8'd3};
      rst_n = 0; in_valid = 0; in_sel = 0; out_ready = 0; in_data = '0;
      set_pattern();
      repeat (2) @(posedge clk);
      #1;
      chk("rst_in_ready", a_in_ready, 0);
      chk("rst_out_valid", a_out_valid, 0);
      chk("rst_out_data", a_out_data, 0);
      chk("rst_b_err", b_err, 0);
      rst_n = 1;
      cycle();
      chk("rel_in_ready", a_in_ready, 1);
      // illegal-select table on NUM_IN=11, one isolated transaction each
      out_ready = 1;
      foreach (tbl[i]) begin
         in_valid = 1; in_sel = tbl[i].sel;
         cycle();
         in_valid = 0;
         chk("tbl_a_data", a_out_data, tbl[i].ad);
         chk("tbl_b_data", b_out_data, tbl[i].bd);
         chk("tbl_b_illegal", b_out_illegal, tbl[i].bil);
         chk("tbl_b_sel", b_out_sel, tbl[i].sel);
         chk("tbl_b_err", b_err, tbl[i].berr);
         cycle();
      end
      // streaming, one per cycle with 1-cycle latency
      in_valid = 1;
      for (int k = 0; k < 16; k++) begin
         in_sel = 4'(k);
         cycle();
         chk("stream_data", a_out_data, 8'hA0 + 8'(k));
         chk("stream_valid", a_out_valid, 1);
      end
      in_valid = 0;
      repeat (2) cycle();
      // backpressure: third offer refused until downstream drains
      out_ready = 0; in_valid = 1;
      in_sel = 1; cycle();
      in_sel = 2; cycle();
      chk("bp_in_ready", a_in_ready, 0);
      in_sel = 3; cycle();
      chk("bp_hold_sel", a_out_sel, 1);
      out_ready = 1; cycle();
      chk("bp_drain1", a_out_sel, 2);
      cycle();
      chk("bp_drain2", a_out_sel, 3);
      in_valid = 0;
      repeat (2) cycle();
      // simultaneous accept and deliver in ONE
      out_ready = 0; in_valid = 1; in_sel = 5; cycle();
      in_sel = 6; out_ready = 1; cycle();
      chk("sim_sel", a_out_sel, 6);
      chk("sim_in_ready", a_in_ready, 1);
      in_valid = 0; cycle();
      // reset with two entries held
      out_ready = 0; in_valid = 1; in_sel = 7; cycle();
      in_sel = 8; cycle();
      in_valid = 0;
      rst_n = 0;
      #1;
      chk("mrst_out_valid", a_out_valid, 0);
      chk("mrst_out_data", a_out_data, 0);
      chk("mrst_out_sel", a_out_sel, 0);
      chk("mrst_in_ready", a_in_ready, 0);
      chk("mrst_b_err", b_err, 0);
      qa.delete(); qb.delete(); ea = 0; eb = 0; m_rdy = 0;
      #1 rst_n = 1;
      out_ready = 1;
      cycle();
      chk("mrst_rel_ready", a_in_ready, 1);
      cycle();
      chk("mrst_no_stale", a_out_valid, 0);
      // saturation of the illegal counter
      in_valid = 1; in_sel = 12;
      repeat (300) cycle();
      chk("sat_err", b_err, 255);
      repeat (5) cycle();
      chk("sat_err_hold", b_err, 255);
      in_valid = 0; cycle();
      // random traffic
      repeat (400) begin
         for (int w = 0; w < 4; w++) in_data[w*32 +: 32] = $urandom;
         in_valid  = ($urandom % 4) != 0;
         in_sel    = 4'($urandom % 16);
         out_ready = ($urandom % 3) != 0;
         cycle();
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
